// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Owns the program counter and sequences next-PC selection for instruction
//   fetch. It starts and stops on trigger, increments by 4, redirects on a taken
//   branch, holds on stall, and inserts flush bubbles after a branch. A
//   misaligned branch target raises a sticky fault.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   trigger      in   run enable (1 = execute, 0 = return to IDLE)
//   stall        in   hold PC this cycle
//   pcsrc        in   branch/jump taken, target = pc + immext
//   immext       in   [DATA_WIDTH]    sign-extended branch offset
//   pc           out  [ADDRESS_WIDTH] current fetch address
//   fetch_valid  out  pc is a valid fetch this cycle
//   flush        out  squash in-flight instructions
//   fault        out  sticky misaligned-target fault
//   fetch_count  out  [32] number of accepted fetches (wraps)
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
  parameter int                         FLUSH_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trigger,
  input  logic                     stall,
  input  logic                     pcsrc,
  input  logic [DATA_WIDTH-1:0]    immext,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic                     fetch_valid,
  output logic                     flush,
  output logic                     fault,
  output logic [31:0]              fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t                   r_state,       w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_pc,          w_pc_nxt;
  logic [31:0]              r_fetch_count, w_fetch_count_nxt;
  logic [3:0]               r_flush_cnt,   w_flush_cnt_nxt;

  logic [ADDRESS_WIDTH-1:0] w_target;
  logic [ADDRESS_WIDTH-1:0] w_pc_inc;

  // Both additions wrap modulo 2^ADDRESS_WIDTH. A negative immext gives a
  // backward branch through the two's-complement add.
  assign w_target = r_pc + immext[ADDRESS_WIDTH-1:0];
  assign w_pc_inc = r_pc + ADDRESS_WIDTH'(4);

  // Next-state and next-value logic.
  always_comb begin
    // NOTE: every signal assigned here receives a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_fetch_count_nxt = r_fetch_count;
    w_flush_cnt_nxt   = r_flush_cnt;

    if (!trigger) begin
      // Dropping trigger wins over every state rule. The fetch count is kept.
      w_state_nxt     = S_IDLE;
      w_pc_nxt        = RESET_PC;
      w_flush_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // Leaving IDLE, pc is already RESET_PC, so the first fetch is there.
          w_state_nxt = S_RUN;
        end

        S_RUN: begin
          // While stalled, pcsrc is ignored. The issuer holds it until the
          // stall drops.
          if (!stall) begin
            w_fetch_count_nxt = r_fetch_count + 32'd1;
            if (!pcsrc) begin
              w_pc_nxt = w_pc_inc;
            end else if (w_target[1:0] != 2'b00) begin
              // A misaligned target freezes pc at the branch's own address.
              w_state_nxt = S_FAULT;
            end else begin
              w_pc_nxt = w_target;
              if (FLUSH_CYCLES > 0) begin
                w_state_nxt     = S_FLUSH;
                w_flush_cnt_nxt = FLUSH_LOAD;
              end
            end
          end
        end

        S_FLUSH: begin
          // The counter holds the remaining bubble count including this
          // cycle, so flush stays high for exactly FLUSH_CYCLES cycles.
          if (r_flush_cnt <= 4'd1) begin
            w_state_nxt     = S_RUN;
            w_flush_cnt_nxt = '0;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 4'd1;
          end
        end

        S_FAULT: begin
          // Sticky state: the only exits are trigger=0 or reset.
          w_state_nxt = S_FAULT;
        end

        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
      r_flush_cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then samples pre-edge values, whatever the statement order.
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_fetch_count <= w_fetch_count_nxt;
      r_flush_cnt   <= w_flush_cnt_nxt;
    end
  end

  assign pc          = r_pc;
  assign fetch_count = r_fetch_count;
  assign fetch_valid = (r_state == S_RUN);
  assign flush       = (r_state == S_FLUSH);
  assign fault       = (r_state == S_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed testbench for pc_sequencer with the default parameters
//   (32-bit PC, RESET_PC = 0, FLUSH_CYCLES = 2). Inputs are driven 1 ns after
//   each rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        trigger;
  logic        stall;
  logic        pcsrc;
  logic [31:0] immext;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        fault;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'h0000_0000),
    .FLUSH_CYCLES  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trigger     (trigger),
    .stall       (stall),
    .pcsrc       (pcsrc),
    .immext      (immext),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .fault       (fault),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the full observable state in one call.
  task automatic expect_state(input string tag, input logic [31:0] e_pc, input logic e_fv,
                              input logic e_fl, input logic e_ft, input logic [31:0] e_cnt);
    check({tag, ".pc"},          pc,          e_pc);
    check({tag, ".fetch_valid"}, fetch_valid, 32'(e_fv));
    check({tag, ".flush"},       flush,       32'(e_fl));
    check({tag, ".fault"},       fault,       32'(e_ft));
    check({tag, ".fetch_count"}, fetch_count, e_cnt);
  endtask

  // Take an aligned branch from RUN, then walk the two flush bubbles.
  task automatic branch(input string tag, input logic [31:0] imm,
                        input logic [31:0] e_pc, input logic [31:0] e_cnt);
    pcsrc  = 1'b1;
    immext = imm;
    step();
    pcsrc  = 1'b0;
    immext = '0;
    expect_state({tag, ".flush1"}, e_pc, 1'b0, 1'b1, 1'b0, e_cnt);
    step();
    expect_state({tag, ".flush2"}, e_pc, 1'b0, 1'b1, 1'b0, e_cnt);
    step();
    expect_state({tag, ".run"},    e_pc, 1'b1, 1'b0, 1'b0, e_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    trigger = 1'b0;
    stall   = 1'b0;
    pcsrc   = 1'b0;
    immext  = '0;
    #12;
    expect_state("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);

    // --- Sequential run: 0,4,8,12, then stop -----------------------------
    rst_n   = 1'b1;
    trigger = 1'b1;
    step();
    expect_state("run0", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(); expect_state("run1", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1);
    step(); expect_state("run2", 32'h8, 1'b1, 1'b0, 1'b0, 32'd2);
    step(); expect_state("run3", 32'hC, 1'b1, 1'b0, 1'b0, 32'd3);
    step(); expect_state("run4", 32'h10, 1'b1, 1'b0, 1'b0, 32'd4);
    trigger = 1'b0;
    step();
    expect_state("stop", 32'h0, 1'b0, 1'b0, 1'b0, 32'd4);

    // --- Forward branch at 0x10 to 0x30 ---------------------------------
    trigger = 1'b1;
    step(); expect_state("restart", 32'h0, 1'b1, 1'b0, 1'b0, 32'd4);
    for (int i = 0; i < 4; i++) step();
    expect_state("pre_br", 32'h10, 1'b1, 1'b0, 1'b0, 32'd8);
    branch("fwd", 32'h20, 32'h30, 32'd9);
    step(); expect_state("after_fwd", 32'h34, 1'b1, 1'b0, 1'b0, 32'd10);

    // --- Backward branch and address wrap -------------------------------
    branch("to40", 32'h0000_000C, 32'h40, 32'd11);
    branch("back", 32'hFFFF_FFF8, 32'h38, 32'd12);
    branch("tomax", 32'hFFFF_FFC4, 32'hFFFF_FFFC, 32'd13);
    step(); expect_state("wrap", 32'h0, 1'b1, 1'b0, 1'b0, 32'd14);

    // --- Stall holding a pending branch at 0x8 --------------------------
    step(); step();
    expect_state("pre_stall", 32'h8, 1'b1, 1'b0, 1'b0, 32'd16);
    stall  = 1'b1;
    pcsrc  = 1'b1;
    immext = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_state("stall", 32'h8, 1'b1, 1'b0, 1'b0, 32'd16);
    end
    stall = 1'b0;
    branch("unstall", 32'h100, 32'h108, 32'd17);

    // --- Misaligned target fault ----------------------------------------
    trigger = 1'b0;
    step(); expect_state("idle2", 32'h0, 1'b0, 1'b0, 1'b0, 32'd17);
    trigger = 1'b1;
    step(); step();
    expect_state("pre_fault", 32'h4, 1'b1, 1'b0, 1'b0, 32'd18);
    pcsrc  = 1'b1;
    immext = 32'h2;
    step();
    pcsrc  = 1'b0;
    immext = '0;
    for (int i = 0; i < 4; i++) begin
      expect_state("fault", 32'h4, 1'b0, 1'b0, 1'b1, 32'd19);
      step();
    end
    trigger = 1'b0;
    step();
    expect_state("fault_clr", 32'h0, 1'b0, 1'b0, 1'b0, 32'd19);

    // --- Asynchronous reset mid-flush -----------------------------------
    trigger = 1'b1;
    step(); expect_state("run_r", 32'h0, 1'b1, 1'b0, 1'b0, 32'd19);
    pcsrc  = 1'b1;
    immext = 32'h10;
    step();
    pcsrc  = 1'b0;
    immext = '0;
    expect_state("mid_flush", 32'h10, 1'b0, 1'b1, 1'b0, 32'd20);
    #2;
    rst_n = 1'b0;
    #1;
    expect_state("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    expect_state("post_rst", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    expect_state("post_rst1", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter register and sequences next-PC selection for instruction fetch: start/stop on `trigger`, sequential increment, taken-branch redirect, stall hold, post-branch flush bubbles, and misaligned-target fault.
- Sits between the control unit (`pcsrc`, `stall`), the immediate extender (`immext`) and instruction memory (`pc`, `fetch_valid`).
- Replaces the separate combinational next-PC selection plus PC register pair with one sequential block.

Parameters:
- ADDRESS_WIDTH, 32, width of PC and instruction address.
- DATA_WIDTH, 32, width of `immext`; must be >= ADDRESS_WIDTH, only the low ADDRESS_WIDTH bits are used.
- RESET_PC, 32'h0000_0000, PC value in reset and IDLE.
- FLUSH_CYCLES, 2, bubble cycles after a taken branch; range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- trigger  input  1  run enable; 1 = execute, 0 = return to IDLE.
- stall  input  1  hold PC this cycle (hazard/memory wait).
- pcsrc  input  1  branch/jump taken; target = pc + immext.
- immext  input  DATA_WIDTH  sign-extended branch offset.
- pc  output  ADDRESS_WIDTH  current fetch address.
- fetch_valid  output  1  `pc` is a valid fetch this cycle.
- flush  output  1  squash in-flight instructions.
- fault  output  1  sticky misaligned-target fault.
- fetch_count  output  32  count of accepted fetches.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, pc=RESET_PC, fetch_valid=0, flush=0, fault=0, fetch_count=0, flush counter=0.
  - Takes effect immediately, including mid-FLUSH or FAULT.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- States: IDLE, RUN, FLUSH, FAULT.
- Priority, highest first: reset > trigger=0 > state-specific rules.
- trigger=0 in any state: next state IDLE, pc<=RESET_PC, flush counter cleared, fault cleared. fetch_count is held, not cleared.
- IDLE:
  - Outputs: fetch_valid=0, pc=RESET_PC.
  - trigger=1 → RUN next cycle. First valid fetch is at RESET_PC.
- RUN (fetch_valid=1; an "accepted fetch" is a RUN cycle with stall=0):
  - stall=1: pc, state and count held. pcsrc ignored; the issuer must hold pcsrc until stall drops.
  - stall=0, pcsrc=0: pc<=pc+4; fetch_count+1.
  - stall=0, pcsrc=1: target = pc + immext[ADDRESS_WIDTH-1:0], modulo 2^ADDRESS_WIDTH.
    - target[1:0]!=0: → FAULT; pc unchanged; fetch_count+1.
    - Else: pc<=target; fetch_count+1.
      - FLUSH_CYCLES>0: → FLUSH with counter=FLUSH_CYCLES.
      - FLUSH_CYCLES=0: stay in RUN.
- FLUSH:
  - Outputs: flush=1, fetch_valid=0; pc holds target.
  - stall and pcsrc are ignored.
  - Counter decrements each cycle; when counter==1 → RUN next cycle.
  - Flush is high for exactly FLUSH_CYCLES cycles.
- FAULT:
  - Outputs: fault=1, fetch_valid=0, pc frozen at the faulting branch's PC.
  - Exit only via trigger=0 (→ IDLE) or reset.
- Arithmetic:
  - pc+4 and pc+immext wrap modulo 2^ADDRESS_WIDTH; no overflow flag.
  - fetch_count wraps 0xFFFF_FFFF → 0.
  - Negative immext yields backward branches via two's-complement add.

Test Plan:
- Reset, trigger=1, no stall/pcsrc for 4 cycles → pc 0,4,8,12 with fetch_valid=1; fetch_count=4; trigger=0 → next cycle pc=0, state IDLE, fetch_count still 4.
- RUN at pc=0x10, pcsrc=1, immext=0x20 → pc=0x30; flush=1 for exactly 2 cycles with fetch_valid=0; then RUN fetch at 0x30, 0x34.
- RUN at pc=0x40, immext=32'hFFFF_FFF8 → pc=0x38, wrapping correctly as a backward branch; and pc=0xFFFF_FFFC, no branch → pc=0x0000_0000.
- stall=1 for 3 cycles with pcsrc=1, immext=0x100 at pc=0x8 → pc stays 0x8, fetch_count unchanged; stall drops → pc=0x108, flush begins.
- pc=0x4, pcsrc=1, immext=0x2 → fault=1, pc stays 0x4, fetch_valid=0 indefinitely; trigger=0 → IDLE, fault=0, pc=0.
- Assert rst_n=0 mid-FLUSH, between clock edges → all outputs return to reset values immediately without a clock edge; release with trigger=1 → fetch at RESET_PC on the following cycle.
